// File: rtl/btn_cmd_gen.sv
// rtl/btn_cmd_gen.sv - debounced button to counter-command pulse generator
//
// Purpose: synchronizes and debounces four push buttons and two mode switches,
//   turns each debounced button press into a single one-cycle command pulse
//   with same-cycle priority reset > set > up/down (up together with down
//   cancels both), and forwards the debounced mode switches as rlr.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   btn_up    in   raw up button (active-high, bouncing)
//   btn_down  in   raw down button
//   btn_set   in   raw set button
//   btn_clr   in   raw clear button
//   mode_sw   in   [1:0] raw mode switches
//   up        out  one-cycle count-up command
//   down      out  one-cycle count-down command
//   set       out  one-cycle preset command
//   reset     out  one-cycle synchronous-clear command
//   rlr       out  [1:0] debounced, registered mode select
//
// Configuration macro: BTN_AUTOREPEAT_EN
//   defined   : held up/down buttons repeat after REP_DELAY, then every REP_PERIOD
//   undefined : no repeat timers, one pulse per press
module btn_cmd_gen #(
   parameter int DB_CYCLES  = 16,
   parameter int REP_DELAY  = 64,
   parameter int REP_PERIOD = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_set,
   input  logic       btn_clr,
   input  logic [1:0] mode_sw,
   output logic       up,
   output logic       down,
   output logic       set,
   output logic       reset,
   output logic [1:0] rlr
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   typedef enum logic {RELEASED = 1'b0, HELD = 1'b1} state_t;

   // Bit order: 0 up, 1 down, 2 set, 3 clr, 5:4 mode_sw
   logic [5:0]    raw;
   logic [5:0]    sync1_q, sync2_q;
   logic [5:0]    stable_q, stable_d;
   logic [CW-1:0] cnt_q [6];
   logic [CW-1:0] cnt_d [6];
   state_t        st_q [4];
   state_t        st_d [4];
   logic [3:0]    rise;
   logic [1:0]    rep;
   logic          up_q, down_q, set_q, reset_q;
   logic          up_d, down_d, set_d, reset_d;
   logic          up_c, down_c;
   logic [1:0]    rlr_q, rlr_d;

   assign raw = {mode_sw, btn_clr, btn_set, btn_down, btn_up};

   // Debounce: the counter only advances while the synchronized value
   // disagrees with the stable bit; any agreeing sample restarts it. It
   // stops at DB_CYCLES, so it can never wrap.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 6; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CW'(DB_CYCLES)) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Button FSMs: a press is recognised on the RELEASED -> HELD transition
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         st_d[b] = st_q[b];
         rise[b] = 1'b0;
         case (st_q[b])
            RELEASED: if (stable_q[b]) begin
               st_d[b] = HELD;
               rise[b] = 1'b1;
            end
            HELD: if (!stable_q[b]) begin
               st_d[b] = RELEASED;
            end
            default: st_d[b] = RELEASED;
         endcase
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] tmr_q [2];
   logic [RW-1:0] tmr_d [2];

   // Down-counting repeat timer per up/down button, armed by the press and
   // reloaded with the period each time it fires while still held.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         tmr_d[i] = tmr_q[i];
         rep[i]   = 1'b0;
         if (rise[i]) begin
            tmr_d[i] = RW'(REP_DELAY);
         end else if (st_q[i] == HELD && stable_q[i]) begin
            if (tmr_q[i] == RW'(1)) begin
               rep[i]   = 1'b1;
               tmr_d[i] = RW'(REP_PERIOD);
            end else begin
               tmr_d[i] = tmr_q[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_q[0] <= '0;
         tmr_q[1] <= '0;
      end else begin
         tmr_q[0] <= tmr_d[0];
         tmr_q[1] <= tmr_d[1];
      end
   end
`else
   // No repeat timers: repeat requests are constant zero whatever the settings
   assign rep = (REP_DELAY > 0 && REP_PERIOD > 0) ? 2'b00 : 2'b00;
`endif

   // Priority: reset beats set beats up/down; simultaneous up and down
   // cancel each other. Losing requests are dropped, never queued.
   always_comb begin
      up_c    = rise[0] | rep[0];
      down_c  = rise[1] | rep[1];
      reset_d = rise[3];
      set_d   = rise[2] & ~rise[3];
      up_d    = up_c & ~down_c & ~rise[2] & ~rise[3];
      down_d  = down_c & ~up_c & ~rise[2] & ~rise[3];
      rlr_d   = stable_q[5:4];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
         for (int b = 0; b < 4; b++) st_q[b] <= RELEASED;
         up_q     <= 1'b0;
         down_q   <= 1'b0;
         set_q    <= 1'b0;
         reset_q  <= 1'b0;
         rlr_q    <= 2'b00;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
         for (int b = 0; b < 4; b++) st_q[b] <= st_d[b];
         up_q     <= up_d;
         down_q   <= down_d;
         set_q    <= set_d;
         reset_q  <= reset_d;
         rlr_q    <= rlr_d;
      end
   end

   assign up    = up_q;
   assign down  = down_q;
   assign set   = set_q;
   assign reset = reset_q;
   assign rlr   = rlr_q;

endmodule

// File: tb/tb_btn_cmd_gen.sv
// tb/tb_btn_cmd_gen.sv - self-checking bench for btn_cmd_gen
module tb_btn_cmd_gen;
   localparam int DB = 4;
   localparam int RD = 8;
   localparam int RP = 4;

   localparam logic [5:0] B_UP  = 6'b000001;
   localparam logic [5:0] B_DN  = 6'b000010;
   localparam logic [5:0] B_SET = 6'b000100;
   localparam logic [5:0] B_CLR = 6'b001000;
   localparam logic [5:0] M_11  = 6'b110000;
   localparam logic [5:0] M_10  = 6'b100000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_set = 1'b0, btn_clr = 1'b0;
   logic [1:0] mode_sw = 2'b00;
   logic       up, down, set, reset;
   logic [1:0] rlr;

   btn_cmd_gen #(.DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
      .clk(clk), .reset_n(reset_n),
      .btn_up(btn_up), .btn_down(btn_down), .btn_set(btn_set), .btn_clr(btn_clr),
      .mode_sw(mode_sw),
      .up(up), .down(down), .set(set), .reset(reset), .rlr(rlr)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: raw samples per edge since reset release, debounced
   // value after the previous two edges, and the edge of the last press.
   logic [5:0] hist [0:4095];
   int         n = 0;
   logic [5:0] sp1 = '0, sp2 = '0;
   int         t_up = -1, t_dn = -1;
   logic       e_up, e_dn, e_set, e_rst;
   logic [1:0] e_rlr;
   int         up_cnt, dn_cnt, set_cnt, rst_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic repeat_due(input logic held, input int t, input int now);
      return held && (t >= 0) && (now - t >= RD) && (((now - t - RD) % RP) == 0);
   endfunction

   task automatic clear_cnt();
      up_cnt = 0; dn_cnt = 0; set_cnt = 0; rst_cnt = 0;
   endtask

   task automatic step(input logic [5:0] raw);
      logic [5:0] nxt;
      logic [3:0] rise;
      logic       rep_u, rep_d, cu, cd, all_diff, v;
      int         idx;
      {mode_sw, btn_clr, btn_set, btn_down, btn_up} = raw;
      @(posedge clk);
      hist[n] = raw;
      // A debounced bit flips once DB+1 consecutive samples (seen two edges
      // late through the synchronizer) all disagree with it.
      nxt = sp1;
      for (int b = 0; b < 6; b++) begin
         all_diff = 1'b1;
         for (int k = 0; k <= DB; k++) begin
            idx = n - 2 - k;
            v = (idx >= 0) ? hist[idx][b] : 1'b0;
            if (v == sp1[b]) all_diff = 1'b0;
         end
         if (all_diff) nxt[b] = ~sp1[b];
      end
      rise = sp1[3:0] & ~sp2[3:0];
      if (rise[0]) t_up = n;
      if (rise[1]) t_dn = n;
      rep_u = 1'b0;
      rep_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_u = repeat_due(sp1[0], t_up, n);
      rep_d = repeat_due(sp1[1], t_dn, n);
`endif
      cu    = rise[0] | rep_u;
      cd    = rise[1] | rep_d;
      e_rst = rise[3];
      e_set = rise[2] & ~rise[3];
      e_up  = cu & ~cd & ~rise[2] & ~rise[3];
      e_dn  = cd & ~cu & ~rise[2] & ~rise[3];
      e_rlr = sp1[5:4];
      sp2 = sp1;
      sp1 = nxt;
      n++;
      #1;
      chk("up", up, e_up);
      chk("down", down, e_dn);
      chk("set", set, e_set);
      chk("reset", reset, e_rst);
      chk("rlr", rlr, e_rlr);
      chk("onehot", ($countones({up, down, set, reset}) <= 1), 1);
      up_cnt  += int'(up);
      dn_cnt  += int'(down);
      set_cnt += int'(set);
      rst_cnt += int'(reset);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_up", up, 0);
      chk("rst_down", down, 0);
      chk("rst_set", set, 0);
      chk("rst_reset", reset, 0);
      chk("rst_rlr", rlr, 0);
      repeat (3) @(posedge clk);
      #1;
      n = 0; sp1 = '0; sp2 = '0; t_up = -1; t_dn = -1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic       val;
      logic       found;
      int         total, len;

      do_reset();

      // Clean up press: one up pulse after edge DB+3, nothing else
      clear_cnt();
      repeat (20) step(B_UP);
      chk("up_press_cnt", up_cnt, 1);
      chk("up_press_others", dn_cnt + set_cnt + rst_cnt, 0);
      repeat (12) step('0);

      // Bouncing down: short bursts never debounce, then one pulse on settle
      clear_cnt();
      val = 1'b0;
      total = 0;
      while (total < 40) begin
         len = $urandom_range(1, 3);
         val = ~val;
         repeat (len) step(val ? B_DN : 6'b0);
         total += len;
      end
      chk("bounce_no_pulse", dn_cnt, 0);
      repeat (15) step(B_DN);
      chk("settle_down_cnt", dn_cnt, 1);
      repeat (12) step('0);

      // set + clr together: only reset
      clear_cnt();
      repeat (15) step(B_SET | B_CLR);
      chk("setclr_reset_cnt", rst_cnt, 1);
      chk("setclr_set_cnt", set_cnt, 0);
      repeat (12) step('0);

      // up + down together: nothing
      clear_cnt();
      repeat (15) step(B_UP | B_DN);
      chk("updown_cnt", up_cnt + dn_cnt, 0);
      repeat (12) step('0);

      // Mode switches 00 -> 11 -> 10
      repeat (50) step(M_11);
      chk("rlr_11", rlr, 2'b11);
      repeat (20) step(M_10);
      chk("rlr_10", rlr, 2'b10);
      repeat (12) step('0);

      // Reset during an up pulse, up held through reset release
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(B_UP);
         if (e_up) found = 1'b1;
      end
      chk("pulse_before_reset", found, 1);
      do_reset();
      clear_cnt();
      repeat (15) step(B_UP);
      chk("held_through_reset_cnt", up_cnt, 1);
      repeat (12) step('0);

      // Reset mid-debounce, button gone afterwards: no stale pulse
      repeat (3) step(B_SET);
      do_reset();
      clear_cnt();
      repeat (15) step('0);
      chk("stale_set_cnt", set_cnt, 0);

      // Long hold of up: repeats only when auto-repeat is built in
      clear_cnt();
      repeat (24) step(B_UP);
      repeat (20) step('0);
`ifdef BTN_AUTOREPEAT_EN
      chk("hold_up_cnt", up_cnt, 5);
`else
      chk("hold_up_cnt", up_cnt, 1);
`endif

      // Randomized segments against the model
      for (int s = 0; s < 60; s++) begin
         logic [5:0] r;
         r = 6'($urandom);
         len = $urandom_range(1, 12);
         repeat (len) step(r);
      end
      repeat (12) step('0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
